// File: rtl/sprite_row_hit_if.sv
// Pixel-stream / bullet / hit-event bundle between the scan pipeline, game logic
// and the sprite row collision detector.
interface sprite_row_hit_if #(
  parameter int INVADERS_H = 11,
  parameter int RES_H      = 640,
  parameter int RES_V      = 480
);
  localparam int XW = $clog2(RES_H) + 1;
  localparam int YW = $clog2(RES_V) + 1;
  localparam int SW = $clog2(INVADERS_H) + 1;

  logic [XW-1:0]         pixel_x;
  logic [YW-1:0]         pixel_y;
  logic                  frame_start;
  logic [SW-1:0]         spr_draw;
  logic                  bullet_active;
  logic [XW-1:0]         bullet_x;
  logic [YW-1:0]         bullet_y;
  logic                  row_load;
  logic [INVADERS_H-1:0] row_init;
  logic                  hit_ack;
  logic [INVADERS_H-1:0] sprites;
  logic                  hit_valid;
  logic [SW-1:0]         hit_idx;
  logic                  row_empty;

  modport master (
    output pixel_x, pixel_y, frame_start, spr_draw, bullet_active,
           bullet_x, bullet_y, row_load, row_init, hit_ack,
    input  sprites, hit_valid, hit_idx, row_empty
  );

  modport slave (
    input  pixel_x, pixel_y, frame_start, spr_draw, bullet_active,
           bullet_x, bullet_y, row_load, row_init, hit_ack,
    output sprites, hit_valid, hit_idx, row_empty
  );
endinterface

// File: rtl/sprite_row_hit.sv
// Bullet vs. sprite-row collision detector: owns the row alive mask, clears the
// first sprite pixel the bullet touches and reports one hit per frame.
module sprite_row_hit #(
  parameter int INVADERS_H = 11,
  parameter int RES_H      = 640,
  parameter int RES_V      = 480,
  parameter int BULLET_W   = 2,
  parameter int BULLET_H   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sprite_row_hit_if.slave bus
);
  localparam int XW = $clog2(RES_H) + 1;
  localparam int YW = $clog2(RES_V) + 1;
  localparam int SW = $clog2(INVADERS_H) + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARMED      = 2'd1,
    PENDING    = 2'd2,
    WAIT_FRAME = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [INVADERS_H-1:0] sprites_q, sprites_d;
  logic                  hit_valid_q, hit_valid_d;
  logic [SW-1:0]         hit_idx_q, hit_idx_d;
  logic                  in_bullet_d_q, in_bullet_d_d;

  // Bounds are widened one bit so bullet_x+BULLET_W cannot wrap at the screen edge.
  logic [XW:0] x_lo, x_hi, x_px;
  logic [YW:0] y_lo, y_hi, y_px;
  logic        in_bullet;

  always_comb begin
    x_lo = {1'b0, bus.bullet_x};
    x_hi = {1'b0, bus.bullet_x} + (XW+1)'(BULLET_W);
    x_px = {1'b0, bus.pixel_x};
    y_lo = {1'b0, bus.bullet_y};
    y_hi = {1'b0, bus.bullet_y} + (YW+1)'(BULLET_H);
    y_px = {1'b0, bus.pixel_y};
    in_bullet = bus.bullet_active &&
                (x_px >= x_lo) && (x_px < x_hi) &&
                (y_px >= y_lo) && (y_px < y_hi);
    in_bullet_d_d = in_bullet;
  end

  // Decode spr_draw against the live mask; out-of-range codes match no bit.
  logic [INVADERS_H-1:0] hit_oh;
  logic                  sel_alive;
  logic                  coin;

  always_comb begin
    hit_oh    = '0;
    sel_alive = 1'b0;
    for (int j = 0; j < INVADERS_H; j++) begin
      if (bus.spr_draw == SW'(j + 1)) begin
        hit_oh[j] = 1'b1;
        sel_alive = sprites_q[j];
      end
    end
    coin = in_bullet_d_q && sel_alive;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; row_load overrides everything.
  always_comb begin
    state_d = state_q;
    if (bus.row_load) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:       state_d = IDLE;
        ARMED:      if (coin)            state_d = PENDING;
        PENDING:    if (bus.hit_ack)     state_d = WAIT_FRAME;
        WAIT_FRAME: if (bus.frame_start) state_d = ARMED;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    sprites_d   = sprites_q;
    hit_valid_d = hit_valid_q;
    hit_idx_d   = hit_idx_q;
    if (bus.row_load) begin
      sprites_d   = bus.row_init;
      hit_valid_d = 1'b0;
      hit_idx_d   = '0;
    end else if (state_q == ARMED && coin) begin
      sprites_d   = sprites_q & ~hit_oh;
      hit_valid_d = 1'b1;
      hit_idx_d   = bus.spr_draw - SW'(1);
    end else if (state_q == PENDING && bus.hit_ack) begin
      hit_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprites_q     <= '0;
      hit_valid_q   <= 1'b0;
      hit_idx_q     <= '0;
      in_bullet_d_q <= 1'b0;
    end else begin
      sprites_q     <= sprites_d;
      hit_valid_q   <= hit_valid_d;
      hit_idx_q     <= hit_idx_d;
      in_bullet_d_q <= in_bullet_d_d;
    end
  end

  assign bus.sprites   = sprites_q;
  assign bus.hit_valid = hit_valid_q;
  assign bus.hit_idx   = hit_idx_q;
  assign bus.row_empty = (sprites_q == '0);
endmodule

// File: tb/tb_sprite_row_hit.sv
// Directed bench for sprite_row_hit: hand-computed mask / hit expectations.
module tb_sprite_row_hit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  sprite_row_hit_if #(.INVADERS_H(11), .RES_H(640), .RES_V(480)) bus ();

  sprite_row_hit #(
    .INVADERS_H(11), .RES_H(640), .RES_V(480), .BULLET_W(2), .BULLET_H(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present pixel (px,py) for one cycle, then drawer code k on the following cycle.
  task automatic coin(input logic [10:0] px, input logic [9:0] py, input logic [4:0] k);
    bus.pixel_x = px;
    bus.pixel_y = py;
    tick();
    bus.pixel_x  = 11'd0;
    bus.pixel_y  = 10'd0;
    bus.spr_draw = k;
    tick();
    bus.spr_draw = 5'd0;
  endtask

  task automatic ack();
    bus.hit_ack = 1'b1;
    tick();
    bus.hit_ack = 1'b0;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.pixel_x = '0; bus.pixel_y = '0; bus.frame_start = 1'b0; bus.spr_draw = '0;
    bus.bullet_active = 1'b0; bus.bullet_x = '0; bus.bullet_y = '0;
    bus.row_load = 1'b0; bus.row_init = '0; bus.hit_ack = 1'b0;

    #12;
    chk("rst_sprites",   32'(bus.sprites), 32'h000);
    chk("rst_empty",     32'(bus.row_empty), 32'd1);
    chk("rst_valid",     32'(bus.hit_valid), 32'd0);
    chk("rst_idx",       32'(bus.hit_idx), 32'd0);
    rst_n = 1'b1;
    tick();

    // Load full row
    bus.row_load = 1'b1; bus.row_init = 11'h7FF;
    tick();
    bus.row_load = 1'b0;
    chk("load_sprites",  32'(bus.sprites), 32'h7FF);
    chk("load_empty",    32'(bus.row_empty), 32'd0);
    chk("load_valid",    32'(bus.hit_valid), 32'd0);

    // First hit on sprite bit 2
    bus.bullet_active = 1'b1; bus.bullet_x = 11'd100; bus.bullet_y = 10'd200;
    coin(11'd100, 10'd200, 5'd3);
    chk("hit1_valid",    32'(bus.hit_valid), 32'd1);
    chk("hit1_idx",      32'(bus.hit_idx), 32'd2);
    chk("hit1_sprites",  32'(bus.sprites), 32'h7FB);
    repeat (5) tick();
    chk("hold_valid",    32'(bus.hit_valid), 32'd1);
    chk("hold_idx",      32'(bus.hit_idx), 32'd2);

    // Coincidence while pending is ignored
    coin(11'd100, 10'd200, 5'd5);
    chk("pend_sprites",  32'(bus.sprites), 32'h7FB);
    chk("pend_idx",      32'(bus.hit_idx), 32'd2);
    ack();
    chk("ack_valid",     32'(bus.hit_valid), 32'd0);

    // WAIT_FRAME ignores coincidences
    coin(11'd101, 10'd207, 5'd5);
    chk("wait_sprites",  32'(bus.sprites), 32'h7FB);
    chk("wait_valid",    32'(bus.hit_valid), 32'd0);
    frame();
    coin(11'd100, 10'd200, 5'd5);
    chk("hit2_valid",    32'(bus.hit_valid), 32'd1);
    chk("hit2_idx",      32'(bus.hit_idx), 32'd4);
    chk("hit2_sprites",  32'(bus.sprites), 32'h7EB);
    ack();
    frame();

    // Non-hits: dead sprite, out-of-range code, bullet inactive, just outside box
    coin(11'd100, 10'd200, 5'd3);
    chk("dead_valid",    32'(bus.hit_valid), 32'd0);
    coin(11'd100, 10'd200, 5'd12);
    chk("oor_valid",     32'(bus.hit_valid), 32'd0);
    bus.bullet_active = 1'b0;
    coin(11'd100, 10'd200, 5'd1);
    chk("inact_valid",   32'(bus.hit_valid), 32'd0);
    bus.bullet_active = 1'b1;
    coin(11'd102, 10'd200, 5'd1);
    chk("xedge_valid",   32'(bus.hit_valid), 32'd0);
    coin(11'd100, 10'd208, 5'd1);
    chk("yedge_valid",   32'(bus.hit_valid), 32'd0);
    coin(11'd99, 10'd200, 5'd1);
    chk("xlow_valid",    32'(bus.hit_valid), 32'd0);
    chk("miss_sprites",  32'(bus.sprites), 32'h7EB);

    // Bottom-right corner of bullet box hits
    coin(11'd101, 10'd207, 5'd1);
    chk("corner_valid",  32'(bus.hit_valid), 32'd1);
    chk("corner_idx",    32'(bus.hit_idx), 32'd0);
    chk("corner_spr",    32'(bus.sprites), 32'h7EA);
    ack();
    frame();

    // Bullet at the top of the coordinate range: bounds must not wrap
    bus.bullet_x = 11'd2047; bus.bullet_y = 10'd1023;
    coin(11'd1, 10'd1023, 5'd4);
    chk("wrapx_valid",   32'(bus.hit_valid), 32'd0);
    coin(11'd2047, 10'd1023, 5'd2);
    chk("maxc_valid",    32'(bus.hit_valid), 32'd1);
    chk("maxc_idx",      32'(bus.hit_idx), 32'd1);
    chk("maxc_spr",      32'(bus.sprites), 32'h7E8);
    ack();
    frame();
    bus.bullet_x = 11'd100; bus.bullet_y = 10'd200;

    // ack and coincidence together in PENDING: ack wins
    coin(11'd100, 10'd200, 5'd4);
    chk("hit3_idx",      32'(bus.hit_idx), 32'd3);
    chk("hit3_spr",      32'(bus.sprites), 32'h7E0);
    bus.pixel_x = 11'd100; bus.pixel_y = 10'd200;
    tick();
    bus.pixel_x = 11'd0; bus.pixel_y = 10'd0;
    bus.spr_draw = 5'd6; bus.hit_ack = 1'b1;
    tick();
    bus.spr_draw = 5'd0; bus.hit_ack = 1'b0;
    chk("ackcoin_valid", 32'(bus.hit_valid), 32'd0);
    chk("ackcoin_spr",   32'(bus.sprites), 32'h7E0);

    // frame_start and coincidence together in WAIT_FRAME: only re-arms
    bus.pixel_x = 11'd100; bus.pixel_y = 10'd200;
    tick();
    bus.pixel_x = 11'd0; bus.pixel_y = 10'd0;
    bus.spr_draw = 5'd6; bus.frame_start = 1'b1;
    tick();
    bus.spr_draw = 5'd0; bus.frame_start = 1'b0;
    chk("fscoin_valid",  32'(bus.hit_valid), 32'd0);
    chk("fscoin_spr",    32'(bus.sprites), 32'h7E0);
    coin(11'd100, 10'd200, 5'd6);
    chk("hit4_idx",      32'(bus.hit_idx), 32'd5);
    chk("hit4_spr",      32'(bus.sprites), 32'h7C0);
    ack();

    // row_load wins over a simultaneous coincidence
    bus.pixel_x = 11'd100; bus.pixel_y = 10'd200;
    tick();
    bus.pixel_x = 11'd0; bus.pixel_y = 10'd0;
    bus.spr_draw = 5'd7; bus.row_load = 1'b1; bus.row_init = 11'h001;
    tick();
    bus.spr_draw = 5'd0; bus.row_load = 1'b0;
    chk("rlcoin_spr",    32'(bus.sprites), 32'h001);
    chk("rlcoin_valid",  32'(bus.hit_valid), 32'd0);
    chk("rlcoin_idx",    32'(bus.hit_idx), 32'd0);
    coin(11'd100, 10'd200, 5'd1);
    chk("last_spr",      32'(bus.sprites), 32'h000);
    chk("last_empty",    32'(bus.row_empty), 32'd1);
    chk("last_valid",    32'(bus.hit_valid), 32'd1);
    chk("last_idx",      32'(bus.hit_idx), 32'd0);

    // Reload, hit, then reset mid-PENDING
    bus.row_load = 1'b1; bus.row_init = 11'h7FF;
    tick();
    bus.row_load = 1'b0;
    coin(11'd100, 10'd200, 5'd9);
    chk("prerst_idx",    32'(bus.hit_idx), 32'd8);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(bus.hit_valid), 32'd0);
    chk("arst_spr",      32'(bus.sprites), 32'h000);
    chk("arst_idx",      32'(bus.hit_idx), 32'd0);
    chk("arst_empty",    32'(bus.row_empty), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    coin(11'd100, 10'd200, 5'd1);
    chk("idle_valid",    32'(bus.hit_valid), 32'd0);
    chk("idle_spr",      32'(bus.sprites), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
